// File: rtl/select_ctrl.sv
`timescale 1ns/1ps
// select_ctrl: synchronous master for a 2-phase select element.
// Accepts a command, sets sel_o, waits SETUP_CYCLES, toggles req_o, then
// reports which synchronised branch output (true/false) toggled.
// Optional feature: define SELECT_CTRL_TIMEOUT_EN for a WAIT-state timeout.
module select_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_sel,
  output logic sel_o,
  output logic req_o,
  input  logic br_true_i,
  input  logic br_false_i,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_branch,
  output logic rsp_err
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  // Reject illegal parameter values at elaboration.
  if (SYNC_STAGES < 2 || SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("select_ctrl: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_t;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync_t, r_sync_f;
  logic                   r_ph_t, r_ph_f;
  logic                   r_ev_t, r_ev_f;
  logic                   r_spur, w_spur_n;
  logic [SW-1:0]          r_setup, w_setup_n;
  logic                   r_cmd_ready, w_cmd_ready_n;
  logic                   r_sel, w_sel_n;
  logic                   r_req, w_req_n;
  logic                   r_rsp_valid, w_rsp_valid_n;
  logic                   r_rsp_branch, w_rsp_branch_n;
  logic                   r_rsp_err, w_rsp_err_n;
  logic                   w_lvl_t, w_lvl_f;
  logic                   w_ev_exp, w_ev_oth;
`ifdef SELECT_CTRL_TIMEOUT_EN
  logic [15:0]            r_to, w_to_n;
`endif

  assign w_lvl_t = r_sync_t[SYNC_STAGES-1];
  assign w_lvl_f = r_sync_f[SYNC_STAGES-1];

  // Branch synchronisers and edge-event detection against the phase registers.
  // The phase register always tracks the last synchronised level, so an
  // event updates it and simultaneous events update both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_t <= '0;
      r_sync_f <= '0;
      r_ph_t   <= 1'b0;
      r_ph_f   <= 1'b0;
      r_ev_t   <= 1'b0;
      r_ev_f   <= 1'b0;
    end else begin
      r_sync_t <= {r_sync_t[SYNC_STAGES-2:0], br_true_i};
      r_sync_f <= {r_sync_f[SYNC_STAGES-2:0], br_false_i};
      r_ev_t   <= w_lvl_t ^ r_ph_t;
      r_ev_f   <= w_lvl_f ^ r_ph_f;
      r_ph_t   <= w_lvl_t;
      r_ph_f   <= w_lvl_f;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_sel        <= 1'b0;
      r_req        <= 1'b0;
      r_setup      <= '0;
      r_spur       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_branch <= 1'b0;
      r_rsp_err    <= 1'b0;
`ifdef SELECT_CTRL_TIMEOUT_EN
      r_to         <= '0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_cmd_ready  <= w_cmd_ready_n;
      r_sel        <= w_sel_n;
      r_req        <= w_req_n;
      r_setup      <= w_setup_n;
      r_spur       <= w_spur_n;
      r_rsp_valid  <= w_rsp_valid_n;
      r_rsp_branch <= w_rsp_branch_n;
      r_rsp_err    <= w_rsp_err_n;
`ifdef SELECT_CTRL_TIMEOUT_EN
      r_to         <= w_to_n;
`endif
    end
  end

  assign w_ev_exp = r_sel ? r_ev_t : r_ev_f;
  assign w_ev_oth = r_sel ? r_ev_f : r_ev_t;

  // Next-state and next-output logic.
  always_comb begin
    w_state_n      = r_state;
    w_sel_n        = r_sel;
    w_req_n        = r_req;
    w_setup_n      = r_setup;
    w_spur_n       = r_spur;
    w_rsp_valid_n  = r_rsp_valid;
    w_rsp_branch_n = r_rsp_branch;
    w_rsp_err_n    = r_rsp_err;
`ifdef SELECT_CTRL_TIMEOUT_EN
    w_to_n         = r_to;
`endif
    if (r_state != S_WAIT && (r_ev_t || r_ev_f)) w_spur_n = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_sel_n   = cmd_sel;
          w_setup_n = SW'(SETUP_CYCLES - 1);
          w_state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_setup == '0) begin
          w_req_n   = ~r_req;
`ifdef SELECT_CTRL_TIMEOUT_EN
          w_to_n    = '0;
`endif
          w_state_n = S_WAIT;
        end else begin
          w_setup_n = r_setup - 1'b1;
        end
      end
      S_WAIT: begin
        if (r_ev_t || r_ev_f) begin
          w_rsp_branch_n = (w_ev_exp) ? r_sel : ~r_sel;
          w_rsp_err_n    = w_ev_oth | r_spur;
          w_rsp_valid_n  = 1'b1;
          w_spur_n       = 1'b0;
          w_state_n      = S_RESP;
        end
`ifdef SELECT_CTRL_TIMEOUT_EN
        else if (r_to == 16'(TIMEOUT_CYCLES)) begin
          w_rsp_branch_n = r_sel;
          w_rsp_err_n    = 1'b1;
          w_rsp_valid_n  = 1'b1;
          w_spur_n       = 1'b0;
          w_state_n      = S_RESP;
        end else begin
          w_to_n = r_to + 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_cmd_ready_n = (w_state_n == S_IDLE);
  end

  assign cmd_ready  = r_cmd_ready;
  assign sel_o      = r_sel;
  assign req_o      = r_req;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_branch = r_rsp_branch;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_select_ctrl.sv
`timescale 1ns/1ps
// Testbench for select_ctrl: table-driven directed vectors, randomized
// commands against a rule-level reference model, plus reset/timeout sequences.
module tb_select_ctrl;

  localparam int SETUP = 2;
  localparam int SYNC  = 2;
  localparam int TMO   = 10;
  localparam int LOOP  = SETUP + SYNC + 2;

  localparam int M_OK    = 0;
  localparam int M_WRONG = 1;
  localparam int M_BOTH  = 2;
  localparam int M_NONE  = 3;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_sel, rsp_ready, br_t, br_f;
  logic cmd_ready, sel_o, req_o, rsp_valid, rsp_branch, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  select_ctrl #(.SYNC_STAGES(SYNC), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .sel_o(sel_o), .req_o(req_o),
    .br_true_i(br_t), .br_false_i(br_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_branch(rsp_branch), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sel;
    int mode;
    bit spur;
    bit exp_br;
    bit exp_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Toggle br_true while the block is idle and let it settle as spurious.
  task automatic inject_spur();
    @(negedge clk);
    br_t = ~br_t;
    repeat (6) @(negedge clk);
  endtask

  // Issue one command, act as the select element per mode, collect response.
  task automatic run_cmd(input bit sel, input int mode, input int hold,
                         output bit br, output bit err, output int lat, output int req_lat);
    int  n;
    bit  r0;
    br = 1'b0; err = 1'b0; lat = -1; req_lat = -1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_wait", int'(cmd_ready), 1);
    if (!cmd_ready) return;
    r0 = req_o;
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("sel_o_after_accept", int'(sel_o), int'(sel));
    check("cmd_ready_low", int'(cmd_ready), 0);
    n = 0;
    while (req_o === r0 && n < 20) begin @(negedge clk); n++; end
    req_lat = n;
    case (mode)
      M_OK:    if (sel) br_t = ~br_t; else br_f = ~br_f;
      M_WRONG: if (sel) br_f = ~br_f; else br_t = ~br_t;
      M_BOTH:  begin br_t = ~br_t; br_f = ~br_f; end
      default: ;
    endcase
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    check("rsp_valid_wait", int'(rsp_valid), 1);
    lat = n;
    br  = rsp_branch;
    err = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      check("rsp_hold", int'({rsp_valid, rsp_branch, rsp_err}), int'({1'b1, br, err}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clear", int'(rsp_valid), 0);
    check("cmd_ready_reassert", int'(cmd_ready), 1);
  endtask

  // Watchdog in case anything stalls beyond all cycle budgets.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    bit   br, err, exp_br, exp_err;
    int   lat, rl;
    bit   s;
    int   m, h;
    bit   sp;

    tbl[0] = '{1, M_OK,    0, 1, 0};
    tbl[1] = '{0, M_OK,    0, 0, 0};
    tbl[2] = '{1, M_WRONG, 0, 0, 1};
    tbl[3] = '{0, M_WRONG, 0, 1, 1};
    tbl[4] = '{1, M_BOTH,  0, 1, 1};
    tbl[5] = '{0, M_BOTH,  0, 0, 1};
    tbl[6] = '{0, M_OK,    0, 0, 0};
    tbl[7] = '{1, M_OK,    1, 1, 1};
    tbl[8] = '{1, M_OK,    0, 1, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; rsp_ready = 1'b0;
    br_t = 1'b0; br_f = 1'b0;
    #2;
    check("reset_outputs", int'({cmd_ready, sel_o, req_o, rsp_valid, rsp_branch, rsp_err}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", int'(cmd_ready), 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].spur) inject_spur();
      run_cmd(tbl[i].sel, tbl[i].mode, i % 3, br, err, lat, rl);
      check($sformatf("vec%0d_req_lat", i), rl, SETUP);
      check($sformatf("vec%0d_rsp_lat", i), lat, LOOP);
      check($sformatf("vec%0d_branch", i), int'(br), int'(tbl[i].exp_br));
      check($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].exp_err));
    end

    // Randomized commands against the rule-level model.
    for (int i = 0; i < 25; i++) begin
      s  = 1'($urandom_range(0, 1));
      m  = int'($urandom_range(0, 2));
      h  = int'($urandom_range(0, 2));
      sp = ($urandom_range(0, 3) == 0);
      exp_br  = (m == M_WRONG) ? ~s : s;
      exp_err = sp || (m != M_OK);
      if (sp) inject_spur();
      run_cmd(s, m, h, br, err, lat, rl);
      check($sformatf("rnd%0d_lat", i), lat, LOOP);
      check($sformatf("rnd%0d_branch", i), int'(br), int'(exp_br));
      check($sformatf("rnd%0d_err", i), int'(err), int'(exp_err));
    end

`ifdef SELECT_CTRL_TIMEOUT_EN
    // No branch response: timeout 11 cycles after the req_o toggle.
    run_cmd(1'b1, M_NONE, 1, br, err, lat, rl);
    check("tmo_lat", lat - rl, TMO + 1);
    check("tmo_branch", int'(br), 1);
    check("tmo_err", int'(err), 1);
    // Late element answer becomes spurious for the next response.
    inject_spur();
    run_cmd(1'b0, M_OK, 0, br, err, lat, rl);
    check("late_branch", int'(br), 0);
    check("late_err", int'(err), 1);
    run_cmd(1'b0, M_OK, 0, br, err, lat, rl);
    check("after_late_err", int'(err), 0);
`endif

    // Reset while waiting for a branch event.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (SETUP + 1) @(negedge clk);
    #2 rst = 1'b1;
    br_t = 1'b0; br_f = 1'b0;
    #1;
    check("async_reset_outputs", int'({cmd_ready, sel_o, req_o, rsp_valid, rsp_branch, rsp_err}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmd(1'b1, M_OK, 1, br, err, lat, rl);
    check("post_reset_lat", lat, LOOP);
    check("post_reset_branch", int'(br), 1);
    check("post_reset_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
